// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: program-memory read port plus the instruction hand-off to control.
// master = fetch unit, slave = control unit and program memory.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [7:0]        op_code;
  logic [7:0]        arg1;
  logic [7:0]        arg2;
  logic              op_valid;
  logic [1:0]        argcount;
  logic              op_done;
  logic              jmp;
  logic [15:0]       jmpaddr;
  logic [ADDR_W-1:0] pc;

  modport master (
    output mem_addr, op_code, arg1, arg2, op_valid, pc,
    input  mem_data, argcount, op_done, jmp, jmpaddr
  );

  modport slave (
    input  mem_addr, op_code, arg1, arg2, op_valid, pc,
    output mem_data, argcount, op_done, jmp, jmpaddr
  );
endinterface

// File: rtl/instr_fetch.sv
// Bytecode fetch/sequencer: reads opcode and up to two operand bytes, holds them until op_done.
// Define FETCH_BRANCH_REL_EN for pc-relative branch targets; absolute targets otherwise.
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  typedef enum logic [2:0] {
    StIssue,
    StOpc,
    StDec,
    StArg2,
    StExec
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        op_code_q, op_code_d;
  logic [7:0]        arg1_q, arg1_d;
  logic [7:0]        arg2_q, arg2_d;
  logic              op_valid_q, op_valid_d;
  logic [1:0]        argc_q, argc_d;

  logic [1:0]        argc_sat;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] mem_addr;

  // An argcount of 3 is not a legal encoding; fetch it as a two-operand instruction.
  assign argc_sat = (bus.argcount == 2'd3) ? 2'd2 : bus.argcount;

`ifdef FETCH_BRANCH_REL_EN
  // Offset is taken from the opcode address, not from the following instruction.
  assign target = pc_q + ADDR_W'($signed(bus.jmpaddr));
`else
  assign target = ADDR_W'(bus.jmpaddr);
`endif

  assign next_pc = bus.jmp ? target : pc_q + ADDR_W'(1) + ADDR_W'(argc_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_code_d = op_code_q;
    arg1_d    = arg1_q;
    arg2_d    = arg2_q;
    argc_d    = argc_q;
    mem_addr  = pc_q;

    unique case (state_q)
      StIssue: begin
        mem_addr = pc_q;
        state_d  = StOpc;
      end
      StOpc: begin
        op_code_d = bus.mem_data;
        arg1_d    = 8'h00;
        arg2_d    = 8'h00;
        mem_addr  = pc_q + ADDR_W'(1);
        state_d   = StDec;
      end
      StDec: begin
        // argcount is decoded by control from op_code_q, which is stable from here on.
        argc_d = argc_sat;
        if (argc_sat == 2'd0) begin
          state_d = StExec;
        end else begin
          arg1_d   = bus.mem_data;
          mem_addr = pc_q + ADDR_W'(2);
          state_d  = (argc_sat == 2'd2) ? StArg2 : StExec;
        end
      end
      StArg2: begin
        arg2_d  = bus.mem_data;
        state_d = StExec;
      end
      StExec: begin
        if (bus.op_done) begin
          pc_d    = next_pc;
          state_d = StIssue;
        end
      end
      default: begin
        state_d = StIssue;
      end
    endcase

    op_valid_d = (state_d == StExec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIssue;
      pc_q       <= PC_RESET;
      op_code_q  <= 8'h00;
      arg1_q     <= 8'h00;
      arg2_q     <= 8'h00;
      op_valid_q <= 1'b0;
      argc_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_code_q  <= op_code_d;
      arg1_q     <= arg1_d;
      arg2_q     <= arg2_d;
      op_valid_q <= op_valid_d;
      argc_q     <= argc_d;
    end
  end

  assign bus.mem_addr = mem_addr;
  assign bus.op_code  = op_code_q;
  assign bus.arg1     = arg1_q;
  assign bus.arg2     = arg2_q;
  assign bus.op_valid = op_valid_q;
  assign bus.pc       = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed program, expected instructions queued by the stimulus thread
// and checked by an independent monitor (contents, fetch latency, stability while held).
module tb_instr_fetch;

  localparam logic [1:0] XNone      = 2'd0;
  localparam logic [1:0] XJmpNoDone = 2'd1;
  localparam logic [1:0] XArgcLatch = 2'd2;
  localparam logic [1:0] XStray     = 2'd3;

`ifdef FETCH_BRANCH_REL_EN
  localparam logic [15:0] JA6  = 16'h000A;  // 0x0006 -> 0x0010
  localparam logic [15:0] JA10 = 16'hFFF8;  // 0x0010 -> 0x0008
  localparam logic [15:0] T    = 16'h0008;
  localparam logic [15:0] JAT3 = 16'hFFF3;  // 0x000B -> 0xFFFE
`else
  localparam logic [15:0] JA6  = 16'h0010;
  localparam logic [15:0] JA10 = 16'h0040;
  localparam logic [15:0] T    = 16'h0040;
  localparam logic [15:0] JAT3 = 16'hFFFE;
`endif

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  op;
    logic [7:0]  a1;
    logic [7:0]  a2;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(16)) bus ();

  instr_fetch #(
    .ADDR_W   (16),
    .PC_RESET (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [65536];
  logic       argc_force_en = 1'b0;
  logic [1:0] argc_force    = 2'd0;
  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic logic [1:0] decode(input logic [7:0] op);
    case (op)
      8'h10:   decode = 2'd1;
      8'h11:   decode = 2'd2;
      8'h13:   decode = 2'd3;
      default: decode = 2'd0;
    endcase
  endfunction

  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];
  assign bus.argcount = argc_force_en ? argc_force : decode(bus.op_code);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: cnt counts edges since the fetch restarted (reset or accepted op_done).
  int         cnt = 0;
  logic       holding = 1'b0;
  exp_t       cur;
  always @(negedge clk) begin
    if (rst || (bus.op_valid && bus.op_done)) begin
      cnt     = 0;
      holding = 1'b0;
    end else begin
      if (bus.op_valid && !holding) begin
        if (exp_q.size() == 0) begin
          check("unexpected op_valid", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("pc", bus.pc, cur.pc);
          check("op_code", bus.op_code, cur.op);
          check("arg1", bus.arg1, cur.a1);
          check("arg2", bus.arg2, cur.a2);
          check("latency", cnt, cur.lat);
        end
        holding = 1'b1;
      end else if (bus.op_valid && holding) begin
        check("held op_code", bus.op_code, cur.op);
        check("held arg1", bus.arg1, cur.a1);
        check("held arg2", bus.arg2, cur.a2);
      end
      cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !bus.op_valid; i++) step();
    check("op_valid arrives", bus.op_valid, 1);
  endtask

  task automatic run_instr(input logic [15:0] epc, input logic [7:0] op, input logic [7:0] a1,
                           input logic [7:0] a2, input int lat, input logic j,
                           input logic [15:0] ja, input logic [15:0] enext,
                           input logic [1:0] extra);
    exp_q.push_back('{epc, op, a1, a2, lat});
    wait_valid();
    step();
    if (extra == XJmpNoDone) begin
      bus.jmp = 1'b1;
      bus.jmpaddr = 16'h0100;
      step();
      bus.jmp = 1'b0;
      check("jmp w/o op_done pc", bus.pc, epc);
      check("jmp w/o op_done op_valid", bus.op_valid, 1);
    end
    if (extra == XArgcLatch) begin
      argc_force_en = 1'b1;
      argc_force    = 2'd0;
      step();
    end
    bus.op_done = 1'b1;
    bus.jmp     = j;
    bus.jmpaddr = ja;
    step();
    bus.op_done   = 1'b0;
    bus.jmp       = 1'b0;
    argc_force_en = 1'b0;
    check("next pc", bus.pc, enext);
    check("op_valid after op_done", bus.op_valid, 0);
    if (extra == XStray) begin
      bus.op_done = 1'b1;
      bus.jmp     = 1'b1;
      bus.jmpaddr = 16'h1234;
      step();
      bus.op_done = 1'b0;
      bus.jmp     = 1'b0;
    end
  endtask

  initial begin
    bus.op_done = 1'b0;
    bus.jmp     = 1'b0;
    bus.jmpaddr = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h02;
    mem[16'h0001] = 8'h10; mem[16'h0002] = 8'h05;
    mem[16'h0003] = 8'h11; mem[16'h0004] = 8'h12; mem[16'h0005] = 8'h34;
    mem[16'h0006] = 8'h20;
    mem[16'h0010] = 8'h21;
    mem[T]        = 8'h13; mem[T + 16'd1] = 8'hAA; mem[T + 16'd2] = 8'hBB;
    mem[T + 16'd3] = 8'h02;
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h77;

    rst = 1'b1;
    step();
    step();
    check("reset pc", bus.pc, 16'h0000);
    check("reset op_valid", bus.op_valid, 0);
    check("reset op_code", bus.op_code, 8'h00);
    check("reset arg1", bus.arg1, 8'h00);
    check("reset arg2", bus.arg2, 8'h00);
    check("reset mem_addr", bus.mem_addr, 16'h0000);
    rst = 1'b0;

    run_instr(16'h0000, 8'h02, 8'h00, 8'h00, 3, 1'b0, 16'h0000, 16'h0001, XNone);
    run_instr(16'h0001, 8'h10, 8'h05, 8'h00, 3, 1'b0, 16'h0000, 16'h0003, XNone);
    run_instr(16'h0003, 8'h11, 8'h12, 8'h34, 4, 1'b0, 16'h0000, 16'h0006, XNone);
    run_instr(16'h0006, 8'h20, 8'h00, 8'h00, 3, 1'b1, JA6, 16'h0010, XNone);
    run_instr(16'h0010, 8'h21, 8'h00, 8'h00, 3, 1'b1, JA10, T, XStray);
    run_instr(T, 8'h13, 8'hAA, 8'hBB, 4, 1'b0, 16'h0000, T + 16'd3, XArgcLatch);
    run_instr(T + 16'd3, 8'h02, 8'h00, 8'h00, 3, 1'b1, JAT3, 16'hFFFE, XNone);
    run_instr(16'hFFFE, 8'h11, 8'h77, 8'h02, 4, 1'b0, 16'h0000, 16'h0001, XJmpNoDone);
    run_instr(16'h0001, 8'h10, 8'h05, 8'h00, 3, 1'b0, 16'h0000, 16'h0003, XNone);

    // Walk the next fetch (pc 0x0003, two operands) into its second-operand cycle, then reset.
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check("mid-fetch reset op_valid", bus.op_valid, 0);
    check("mid-fetch reset pc", bus.pc, 16'h0000);
    check("mid-fetch reset op_code", bus.op_code, 8'h00);
    check("mid-fetch reset arg1", bus.arg1, 8'h00);
    check("mid-fetch reset arg2", bus.arg2, 8'h00);
    check("mid-fetch reset mem_addr", bus.mem_addr, 16'h0000);
    rst = 1'b0;

    run_instr(16'h0000, 8'h02, 8'h00, 8'h00, 3, 1'b0, 16'h0000, 16'h0001, XNone);
    step();
    step();
    check("scoreboard drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
